// File: rtl/psum_spad_ctrl.sv
// -----------------------------------------------------------------------------
// psum_spad_ctrl
//
// Sequencer for one partial-sum pass of a PE:
//   1. clear the psum scratch pad,
//   2. accumulate FILT_LEN MACs into each of NUM_PSUM psum entries,
//   3. drain the NUM_PSUM finished psums into the output FIFO,
//   4. pulse done.
//
// Flow control:
//   A transfer happens only in a cycle where the source has data and the sink
//   has room, and it completes in that same cycle.
//   - Operand FIFO: in_empty low means data is available. in_ren is raised
//     only in those cycles, and the MAC is taken in that cycle.
//   - Drain path: spad_empty low means a psum is available, and out_full low
//     means the output FIFO has room. spad_ren and out_wen are raised together
//     only when both are true. The scratch-pad read is combinational, so the
//     data is written to the output FIFO in the same cycle.
//   Counters advance only on transfer cycles. Every other cycle is a stall.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   start                          begin one pass (sampled in IDLE only)
//   abort                          synchronous cancel of the current pass
//   in_empty / in_ren              operand FIFO flag / read enable
//   spad_wen, spad_ren, spad_clear,
//   spad_freeze, spad_same_addr    psum scratch pad controls
//   spad_empty                     psum scratch pad empty flag
//   out_full / out_wen             output FIFO flag / write enable
//   acc_first                      datapath adds zero instead of read-back psum
//   busy                           high in every state except IDLE
//   done                           one-cycle pass-complete pulse
//   dbg_state                      current FSM state (see state_e encoding)
// -----------------------------------------------------------------------------
module psum_spad_ctrl #(
  parameter int FILT_LEN = 3,
  parameter int NUM_PSUM = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic       in_empty,
  output logic       in_ren,
  output logic       spad_wen,
  output logic       spad_ren,
  output logic       spad_clear,
  output logic       spad_freeze,
  output logic       spad_same_addr,
  input  logic       spad_empty,
  input  logic       out_full,
  output logic       out_wen,
  output logic       acc_first,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int MW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int PW = (NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1;

  localparam logic [MW-1:0] MAC_LAST  = MW'(FILT_LEN - 1);
  localparam logic [PW-1:0] PSUM_LAST = PW'(NUM_PSUM - 1);
  localparam logic [MW-1:0] MAC_ONE   = MW'(1);
  localparam logic [PW-1:0] PSUM_ONE  = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   mac_cnt_q, mac_cnt_d;
  logic [PW-1:0]   psum_cnt_q, psum_cnt_d;

  logic            in_step;     // operand available this ACC cycle
  logic            drain_step;  // psum available and output FIFO has room
  logic            abort_hit;   // abort takes effect this cycle

  assign in_step    = !in_empty;
  assign drain_step = !out_full && !spad_empty;
  assign abort_hit  = abort && (state_q != S_IDLE);

  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      mac_cnt_q  <= '0;
      psum_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mac_cnt_q  <= mac_cnt_d;
      psum_cnt_q <= psum_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mac_cnt_d  = mac_cnt_q;
    psum_cnt_d = psum_cnt_q;

    if (abort_hit) begin
      // Abort wins over every other transition.
      state_d    = S_IDLE;
      mac_cnt_d  = '0;
      psum_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mac_cnt_d  = '0;
          psum_cnt_d = '0;
          if (start) state_d = S_CLEAR;
        end

        S_CLEAR: state_d = S_ACC;

        S_ACC: begin
          if (in_step) begin
            if (mac_cnt_q == MAC_LAST) begin
              // Last MAC of this psum: move to the next entry.
              mac_cnt_d = '0;
              if (psum_cnt_q == PSUM_LAST) begin
                psum_cnt_d = '0;
                state_d    = S_DRAIN;
              end else begin
                psum_cnt_d = psum_cnt_q + PSUM_ONE;
              end
            end else begin
              mac_cnt_d = mac_cnt_q + MAC_ONE;
            end
          end
        end

        S_DRAIN: begin
          if (drain_step) begin
            if (psum_cnt_q == PSUM_LAST) begin
              psum_cnt_d = '0;
              state_d    = S_DONE;
            end else begin
              psum_cnt_d = psum_cnt_q + PSUM_ONE;
            end
          end
        end

        S_DONE: begin
          mac_cnt_d  = '0;
          psum_cnt_d = '0;
          state_d    = S_IDLE;
        end

        default: begin
          state_d    = S_IDLE;
          mac_cnt_d  = '0;
          psum_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ren         = 1'b0;
    spad_wen       = 1'b0;
    spad_ren       = 1'b0;
    spad_clear     = 1'b0;
    spad_freeze    = 1'b0;
    spad_same_addr = 1'b0;
    out_wen        = 1'b0;
    acc_first      = 1'b0;
    done           = 1'b0;
    busy           = (state_q != S_IDLE);

    if (abort_hit) begin
      // Wipe any partially accumulated psums. All other controls stay low.
      spad_clear = 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: spad_clear = 1'b1;

        S_ACC: begin
          // The first MAC of a psum adds zero, even while stalled, so the
          // datapath operand select stays stable across the stall.
          spad_same_addr = 1'b1;
          acc_first      = (mac_cnt_q == '0);
          if (in_step) begin
            in_ren      = 1'b1;
            spad_wen    = 1'b1;
            // The write pointer advances only after the last MAC of an entry.
            spad_freeze = (mac_cnt_q != MAC_LAST);
          end else begin
            spad_freeze = 1'b1;
          end
        end

        S_DRAIN: begin
          if (drain_step) begin
            spad_ren = 1'b1;
            out_wen  = 1'b1;
          end
        end

        S_DONE: done = 1'b1;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_spad_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for psum_spad_ctrl.
//
// Two instances share every input:
//   dut_a: FILT_LEN=3, NUM_PSUM=2
//   dut_b: FILT_LEN=1, NUM_PSUM=3
//
// The reference model does not copy the controller's counters. For each
// instance it tracks the pass phase, the total number of MAC steps taken
// (k), and the number of psums drained (d). It derives every expected
// output from these using plain arithmetic.
//
// Output vector bit order:
//   [9] in_ren      [8] spad_wen        [7] spad_ren  [6] spad_clear
//   [5] spad_freeze [4] spad_same_addr  [3] out_wen   [2] acc_first
//   [1] busy        [0] done
// -----------------------------------------------------------------------------
module tb_psum_spad_ctrl;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Shared stimulus and DUT outputs
  // ---------------------------------------------------------------------------
  logic rstn, start, abort, in_empty, spad_empty, out_full;

  wire [9:0] out_a, out_b;
  wire [2:0] dbg_a, dbg_b;

  psum_spad_ctrl #(.FILT_LEN(3), .NUM_PSUM(2)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .in_empty(in_empty), .in_ren(out_a[9]),
    .spad_wen(out_a[8]), .spad_ren(out_a[7]), .spad_clear(out_a[6]),
    .spad_freeze(out_a[5]), .spad_same_addr(out_a[4]),
    .spad_empty(spad_empty), .out_full(out_full), .out_wen(out_a[3]),
    .acc_first(out_a[2]), .busy(out_a[1]), .done(out_a[0]),
    .dbg_state(dbg_a)
  );

  psum_spad_ctrl #(.FILT_LEN(1), .NUM_PSUM(3)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .in_empty(in_empty), .in_ren(out_b[9]),
    .spad_wen(out_b[8]), .spad_ren(out_b[7]), .spad_clear(out_b[6]),
    .spad_freeze(out_b[5]), .spad_same_addr(out_b[4]),
    .spad_empty(spad_empty), .out_full(out_full), .out_wen(out_b[3]),
    .acc_first(out_b[2]), .busy(out_b[1]), .done(out_b[0]),
    .dbg_state(dbg_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_ACC   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  int fl[2] = '{3, 1};   // FILT_LEN per instance
  int np[2] = '{2, 3};   // NUM_PSUM per instance
  int ph[2];             // pass phase
  int k[2];              // total MAC steps taken in the current pass
  int d[2];              // psums drained in the current pass

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cyc = -1;
  bit done_seen = 1'b0;

  // Expected outputs for instance i, given its phase and the current inputs.
  function automatic logic [9:0] exp_out(int i);
    logic [9:0] e;
    int m;
    e = '0;
    if (!rstn) return e;
    if (ph[i] != P_IDLE && abort) begin
      e[6] = 1'b1;
      e[1] = 1'b1;
      return e;
    end
    case (ph[i])
      P_CLEAR: begin
        e[6] = 1'b1;
        e[1] = 1'b1;
      end
      P_ACC: begin
        m    = k[i] % fl[i];
        e[1] = 1'b1;
        e[4] = 1'b1;
        e[2] = (m == 0);
        if (!in_empty) begin
          e[9] = 1'b1;
          e[8] = 1'b1;
          e[5] = (m != fl[i] - 1);
        end else begin
          e[5] = 1'b1;
        end
      end
      P_DRAIN: begin
        e[1] = 1'b1;
        if (!out_full && !spad_empty) begin
          e[7] = 1'b1;
          e[3] = 1'b1;
        end
      end
      P_DONE: begin
        e[1] = 1'b1;
        e[0] = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Advance the model by one rising clock edge.
  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      if (!rstn || (ph[i] != P_IDLE && abort)) begin
        ph[i] = P_IDLE;
        k[i]  = 0;
        d[i]  = 0;
      end else begin
        case (ph[i])
          P_IDLE:  if (start) ph[i] = P_CLEAR;
          P_CLEAR: ph[i] = P_ACC;
          P_ACC: begin
            if (!in_empty) begin
              k[i]++;
              if (k[i] == fl[i] * np[i]) begin
                ph[i] = P_DRAIN;
                k[i]  = 0;
              end
            end
          end
          P_DRAIN: begin
            if (!out_full && !spad_empty) begin
              d[i]++;
              if (d[i] == np[i]) begin
                ph[i] = P_DONE;
                d[i]  = 0;
              end
            end
          end
          P_DONE:  ph[i] = P_IDLE;
          default: ph[i] = P_IDLE;
        endcase
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------

  // Compare both instances against the model; record A's done cycle.
  task automatic check_cycle();
    logic [9:0] ea, eb;
    ea = exp_out(0);
    eb = exp_out(1);
    checks++;
    assert (out_a === ea) else begin
      failures++;
      $error("FAIL outs_a cyc=%0d observed=%b expected=%b", cyc, out_a, ea);
    end
    checks++;
    assert (out_b === eb) else begin
      failures++;
      $error("FAIL outs_b cyc=%0d observed=%b expected=%b", cyc, out_b, eb);
    end
    if (out_a[0] === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  endtask

  // Inputs are set by the caller just after a rising edge. Outputs are
  // checked on the falling edge, then the model steps on the rising edge.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_advance();
    cyc++;
    #1;
  endtask

  task automatic begin_scenario();
    cyc       = 0;
    done_cyc  = -1;
    done_seen = 1'b0;
  endtask

  task automatic check_int(string tag, int obs, int expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    in_empty   = 1'b0;
    spad_empty = 1'b0;
    out_full   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ph[i] = P_IDLE;
      k[i]  = 0;
      d[i]  = 0;
    end

    // Reset state.
    #3;
    checks++;
    assert (out_a === 10'd0 && out_b === 10'd0) else begin
      failures++;
      $error("FAIL reset_outs observed=%b/%b expected=0", out_a, out_b);
    end
    @(posedge clk);
    model_advance();
    #1;
    rstn = 1'b1;
    repeat (2) step();

    // Nominal pass. start is re-asserted mid-pass and must be ignored.
    begin_scenario();
    start = 1'b1;
    step();
    for (int c = 1; c < 14; c++) begin
      start = (c >= 3 && c <= 6);
      step();
    end
    start = 1'b0;
    check_int("done_cycle_nominal", done_cyc, 10);

    // Operand stall in cycles 3-4.
    begin_scenario();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 15; c++) begin
      in_empty = (c == 3 || c == 4);
      step();
    end
    in_empty = 1'b0;
    check_int("done_cycle_in_stall", done_cyc, 12);

    // Output FIFO full in cycle 8.
    begin_scenario();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 14; c++) begin
      out_full = (c == 8);
      step();
    end
    out_full = 1'b0;
    check_int("done_cycle_out_full", done_cyc, 11);

    // Abort in cycle 5: done must never be seen.
    begin_scenario();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 12; c++) begin
      abort = (c == 5);
      step();
    end
    abort = 1'b0;
    check_int("abort_no_done", int'(done_seen), 0);

    // After the abort, the next pass runs the full nominal sequence.
    begin_scenario();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 13; c++) step();
    check_int("done_cycle_after_abort", done_cyc, 10);

    // Asynchronous reset mid-ACC, then a start-free idle window.
    begin_scenario();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rstn = 1'b0;
    #1;
    checks++;
    assert (out_a === 10'd0 && out_b === 10'd0) else begin
      failures++;
      $error("FAIL async_reset_outs observed=%b/%b expected=0", out_a, out_b);
    end
    start = 1'b1;
    repeat (2) step();
    start = 1'b0;
    rstn  = 1'b1;
    repeat (4) step();
    check_int("reset_no_done", int'(done_seen), 0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 49) == 0);
      in_empty   = ($urandom_range(0, 3) == 0);
      out_full   = ($urandom_range(0, 3) == 0);
      spad_empty = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
